// File: rtl/product_accumulator.sv
// product_accumulator: sums groups of COUNT 8-bit products and
// presents each group total with a sticky carry flag on valid/ready.
module product_accumulator #(
  parameter int ACC_W = 12,
  parameter int COUNT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       p,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] sum,
  output logic             ovf
);

  typedef enum logic {
    ACCUM,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] sum_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             ovf_r_q, ovf_r_d;
  logic             ovf_d;
  logic [ACC_W:0]   add;
  logic             take;
  logic             give;
  logic             last;

  // one extra bit catches the single possible carry per accept
  assign add = {1'b0, acc_q}
             + {{(ACC_W-7){1'b0}}, p};

  assign in_ready  = (state_q == ACCUM);
  assign out_valid = (state_q == DONE);
  assign take      = in_valid & in_ready;
  assign give      = out_valid & out_ready;
  assign last      = (cnt_q == 8'(COUNT-1));

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_r_d = ovf_r_q;
    sum_d   = sum;
    ovf_d   = ovf;
    priority case (1'b1)
      clr: begin
        state_d = ACCUM;
        acc_d   = '0;
        cnt_d   = '0;
        ovf_r_d = 1'b0;
        sum_d   = '0;
        ovf_d   = 1'b0;
      end
      take && last: begin
        sum_d   = add[ACC_W-1:0];
        ovf_d   = ovf_r_q | add[ACC_W];
        acc_d   = '0;
        cnt_d   = '0;
        ovf_r_d = 1'b0;
        state_d = DONE;
      end
      take: begin
        acc_d   = add[ACC_W-1:0];
        cnt_d   = cnt_q + 8'd1;
        ovf_r_d = ovf_r_q | add[ACC_W];
      end
      give: begin
        state_d = ACCUM;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ACCUM;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_r_q <= 1'b0;
      sum     <= '0;
      ovf     <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_r_q <= ovf_r_d;
      sum     <= sum_d;
      ovf     <= ovf_d;
    end
  end

endmodule

// File: tb/tb_product_accumulator.sv
// tb_product_accumulator: scoreboard bench driving a 12-bit and a
// 9-bit accumulator in lockstep from the same product stream.
module tb_product_accumulator;

  logic        clk;
  logic        rst_n;
  logic        clr;
  logic        in_valid;
  logic [7:0]  p;
  logic        out_ready;
  logic        ir12, ov12, o12;
  logic [11:0] s12;
  logic        ir9, ov9, o9;
  logic [8:0]  s9;

  product_accumulator #(.ACC_W(12), .COUNT(4)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .in_valid(in_valid), .in_ready(ir12), .p(p),
    .out_valid(ov12), .out_ready(out_ready),
    .sum(s12), .ovf(o12)
  );

  product_accumulator #(.ACC_W(9), .COUNT(4)) dut9 (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .in_valid(in_valid), .in_ready(ir9), .p(p),
    .out_valid(ov9), .out_ready(out_ready),
    .sum(s9), .ovf(o9)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [11:0] s12;
    logic        o12;
    logic [8:0]  s9;
    logic        o9;
  } exp_t;

  exp_t sb[$];
  exp_t m_last;
  int   m_tot;
  int   m_cnt;
  logic m_done;
  int   n_checks;
  int   n_fail;

  function automatic logic [26:0] obs();
    return {ov12, ir12, s12, o12, ov9, ir9, s9, o9};
  endfunction

  function automatic logic [26:0] expv();
    exp_t e;
    e = (m_done && sb.size() > 0) ? sb[0] : m_last;
    return {m_done, !m_done, e.s12, e.o12,
            m_done, !m_done, e.s9, e.o9};
  endfunction

  task automatic model_clear();
    m_tot  = 0;
    m_cnt  = 0;
    m_done = 1'b0;
    m_last = '0;
    sb.delete();
  endtask

  // drive one cycle and advance the reference model
  task automatic cyc(input logic iv, input logic [7:0] v,
                     input logic ordy);
    logic acc_hs, out_hs;
    exp_t e;
    in_valid  = iv;
    p         = v;
    out_ready = ordy;
    acc_hs = iv && !m_done;
    out_hs = m_done && ordy;
    @(posedge clk);
    #1;
    if (out_hs) begin
      if (sb.size() > 0) m_last = sb.pop_front();
      m_done = 1'b0;
    end
    if (acc_hs) begin
      m_tot += int'(v);
      m_cnt++;
      if (m_cnt == 4) begin
        e.s12 = m_tot[11:0];
        e.o12 = (m_tot >= 4096);
        e.s9  = m_tot[8:0];
        e.o9  = (m_tot >= 512);
        sb.push_back(e);
        m_tot  = 0;
        m_cnt  = 0;
        m_done = 1'b1;
      end
    end
  endtask

  task automatic test_reset();
    n_checks++;
    if (obs() !== expv()) begin
      n_fail++;
      $display("FAIL reset_hold: got %h want %h", obs(), expv());
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if (obs() !== expv()) begin
      n_fail++;
      $display("FAIL reset_release: got %h want %h", obs(), expv());
    end
  endtask

  task automatic test_basic_and_wrap();
    logic [7:0] pat [8];
    pat = '{225, 225, 225, 225, 1, 2, 3, 4};
    for (int g = 0; g < 2; g++) begin
      for (int i = 0; i < 4; i++) begin
        cyc(1'b1, pat[g*4+i], 1'b1);
        n_checks++;
        if (obs() !== expv()) begin
          n_fail++;
          $display("FAIL group%0d_acc%0d: got %h want %h",
                   g, i, obs(), expv());
        end
      end
      cyc(1'b0, 8'd0, 1'b1);
      n_checks++;
      if (obs() !== expv()) begin
        n_fail++;
        $display("FAIL group%0d_handshake: got %h want %h",
                 g, obs(), expv());
      end
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] pat [4];
    pat = '{10, 20, 30, 40};
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, pat[i], 1'b0);
      if (i < 3) cyc(1'b0, 8'd0, 1'b0);
    end
    n_checks++;
    if (obs() !== expv()) begin
      n_fail++;
      $display("FAIL bp_done: got %h want %h", obs(), expv());
    end
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, 8'd99, 1'b0);
      n_checks++;
      if (obs() !== expv()) begin
        n_fail++;
        $display("FAIL bp_hold%0d: got %h want %h", i, obs(), expv());
      end
    end
    cyc(1'b1, 8'd99, 1'b1);
    n_checks++;
    if (obs() !== expv()) begin
      n_fail++;
      $display("FAIL bp_release: got %h want %h", obs(), expv());
    end
    cyc(1'b1, 8'd99, 1'b1);
    for (int i = 0; i < 3; i++) cyc(1'b1, 8'd1, 1'b1);
    n_checks++;
    if (obs() !== expv()) begin
      n_fail++;
      $display("FAIL bp_next_group: got %h want %h", obs(), expv());
    end
    cyc(1'b0, 8'd0, 1'b1);
  endtask

  task automatic test_reset_mid();
    cyc(1'b1, 8'd50, 1'b1);
    cyc(1'b1, 8'd60, 1'b1);
    in_valid = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    model_clear();
    n_checks++;
    if (obs() !== expv()) begin
      n_fail++;
      $display("FAIL async_reset: got %h want %h", obs(), expv());
    end
    #1;
    rst_n = 1'b1;
    cyc(1'b0, 8'd0, 1'b1);
    for (int i = 0; i < 4; i++) cyc(1'b1, 8'd1, 1'b1);
    n_checks++;
    if (obs() !== expv()) begin
      n_fail++;
      $display("FAIL after_reset_group: got %h want %h", obs(), expv());
    end
    cyc(1'b0, 8'd0, 1'b1);
  endtask

  task automatic test_clr();
    for (int i = 0; i < 4; i++) cyc(1'b1, 8'd225, 1'b0);
    clr       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    model_clear();
    n_checks++;
    if (obs() !== expv()) begin
      n_fail++;
      $display("FAIL clr_in_done: got %h want %h", obs(), expv());
    end
    cyc(1'b1, 8'd5, 1'b1);
    clr      = 1'b1;
    in_valid = 1'b1;
    p        = 8'd7;
    @(posedge clk);
    #1;
    clr = 1'b0;
    model_clear();
    for (int i = 1; i <= 4; i++) begin
      cyc(1'b1, 8'(i), 1'b1);
      n_checks++;
      if (obs() !== expv()) begin
        n_fail++;
        $display("FAIL clr_accum%0d: got %h want %h", i, obs(), expv());
      end
    end
    cyc(1'b0, 8'd0, 1'b1);
  endtask

  task automatic test_random();
    int groups;
    int cycles;
    logic [3:0] a, b;
    logic [7:0] v;
    logic iv, ordy;
    groups = 0;
    cycles = 0;
    while (groups < 40 && cycles < 4000) begin
      a    = 4'($urandom_range(0, 15));
      b    = 4'($urandom_range(0, 15));
      v    = {4'b0, a} * {4'b0, b};
      iv   = ($urandom_range(0, 3) != 0);
      ordy = 1'($urandom_range(0, 1));
      if (m_done && ordy) groups++;
      cyc(iv, v, ordy);
      cycles++;
      n_checks++;
      if (obs() !== expv()) begin
        n_fail++;
        $display("FAIL rand_cycle%0d: got %h want %h",
                 cycles, obs(), expv());
      end
    end
    if (groups < 40) begin
      n_checks++;
      n_fail++;
      $display("FAIL rand_timeout: got %0d groups want 40", groups);
    end
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    clr       = 1'b0;
    in_valid  = 1'b0;
    p         = 8'd0;
    out_ready = 1'b0;
    model_clear();
    #12;
    test_reset();
    test_basic_and_wrap();
    test_backpressure();
    test_reset_mid();
    test_clr();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/product_accumulator.md
# product_accumulator

Sequential accumulation stage directly downstream of the 4-bit binary multiplier. It consumes the multiplier's 8-bit products one per accepted handshake and sums a fixed-size group of COUNT products. It then presents the group total, with an overflow flag, on a valid/ready output port. It lets the combinational multiplier feed a dot-product / multiply-accumulate datapath.

## Interface
- ACC_W, default 12: accumulator and result width in bits; legal range 8..32.
- COUNT, default 4: products per group; legal range 2..255.
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- clr  input  1  synchronous group abort; highest priority after rst_n.
- in_valid  input  1  upstream product p is valid this cycle.
- in_ready  output  1  block can accept a product this cycle.
- p  input  8  unsigned product from the multiplier.
- out_valid  output  1  sum/ovf hold a completed group result.
- out_ready  input  1  downstream accepts the result this cycle.
- sum  output  ACC_W  group total, modulo 2^ACC_W.
- ovf  output  1  a carry out of ACC_W occurred during this group.

## Operation
- The state machine has two states.
  - ACCUM: collecting products; in_ready=1, out_valid=0.
  - DONE: result held; in_ready=0, out_valid=1.
- Input accept: in_valid && in_ready at a rising edge.
  - acc <= acc + p, with p zero-extended.
  - cnt <= cnt + 1.
  - ovf_r is set on carry out of ACC_W and is sticky for the group.
- Group completion: the accept happens while cnt == COUNT-1.
  - sum <= acc + p, wrapped.
  - ovf <= ovf_r | carry.
  - acc, cnt and ovf_r clear.
  - State goes to DONE.
- Output handshake: out_valid && out_ready at a rising edge.
  - State goes to ACCUM.
  - sum and ovf keep their last values; they are only meaningful while out_valid=1.
- In DONE, in_valid is ignored and no product is consumed.
- In ACCUM, out_ready is ignored.
- clr=1 at an edge:
  - acc, cnt and ovf_r clear and state goes to ACCUM.
  - A pending result in DONE is discarded, and sum/ovf clear to 0.
  - A simultaneous input or output handshake is not performed.
- in_ready and out_valid are decoded from state only, with no combinational path from in_valid or out_ready.
- Arithmetic is unsigned. A single 8-bit add into ACC_W bits yields at most one carry per accept.

## Timing
- Reset (rst_n=0, asynchronous) clears everything:
  - state is ACCUM, acc=0, cnt=0, ovf_r=0.
  - Outputs: sum=0, ovf=0, out_valid=0, in_ready=1.
- Throughput: one product per cycle while in ACCUM.
- Latency:
  - The COUNT-th accept at edge k raises out_valid immediately after edge k.
  - The output handshake at edge m raises in_ready immediately after edge m.
  - Minimum group period is COUNT+1 cycles.
- Backpressure: while out_ready=0 in DONE, sum, ovf and out_valid hold stable indefinitely.
- in_valid gaps: a cycle with in_valid=0 changes no state.
- Reset asserted mid-group or in DONE discards partial or pending results. Operation resumes in ACCUM on the first edge after deassertion.
- cnt wrap: cnt never exceeds COUNT-1; it is cleared on completion, not on overflow.

## Test plan
- Basic group (ACC_W=12, COUNT=4): p = 225, 225, 225, 225 on 4 consecutive cycles with out_ready=1 -> out_valid=1 for one cycle after edge 4, sum=900 (0x384), ovf=0; in_ready=1 again on the following cycle.
- Overflow wrap (ACC_W=9, COUNT=4): p = 225 ×4 -> sum=388 (900 mod 512), ovf=1. The next group p = 1, 2, 3, 4 -> sum=10, ovf=0, showing ovf does not leak across groups.
- Backpressure and gaps:
  - Stimulus: p = 10, 20, 30, 40 with in_valid low on alternate cycles, then out_ready=0 for 5 cycles while in_valid=1 with p=99.
  - Required response: sum=100 held stable and in_ready=0 for all 5 cycles; 99 is not consumed.
  - Raising out_ready completes the handshake and the next group starts with 99.
- Reset mid-group: accept p = 50, 60, then pull rst_n low asynchronously between edges -> outputs immediately show sum=0, ovf=0, out_valid=0, in_ready=1. The next group p = 1, 1, 1, 1 gives sum=4.
- clr priority:
  - Stimulus: in DONE with sum=900, assert clr in the same cycle as out_ready=1.
  - Required response: out_valid=0, sum=0 and state ACCUM after the edge.
  - Second case: clr asserted with in_valid=1 and p=7 in ACCUM -> p is not accumulated and cnt=0.
- Randomised multiplier feed: drive p = a*b from random 4-bit a, b for 40 groups with random out_ready -> each sum equals the reference sum of its COUNT products mod 2^ACC_W, and ovf matches the reference carry.
